// File: rtl/step_counter.sv
// Up/down counter with a programmable step, wrap or clamp at the bounds,
// a sticky overflow/underflow flag and a one-cycle terminal-crossing pulse.
module step_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] sum,
  output logic             stat,
  output logic             tc
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};

  logic [WIDTH-1:0] sum_r;
  logic             stat_r;
  logic             tc_r;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             cross_s;
  logic [WIDTH-1:0] next_sum_s;
  logic             next_stat_s;
  logic             next_tc_s;

  // Next-state: load beats a step; the extra top bit of the widened result
  // is the carry (up) or borrow (down) that marks a crossing.
  always_comb begin
    add_s       = {1'b0, sum_r} + STEP_EXT;
    sub_s       = {1'b0, sum_r} - STEP_EXT;
    cross_s     = 1'b0;
    next_sum_s  = sum_r;
    next_tc_s   = 1'b0;
    next_stat_s = stat_r;
    if (load) begin
      next_sum_s = load_val;
    end else if (en) begin
      if (up) begin
        cross_s    = add_s[WIDTH];
        next_sum_s = add_s[WIDTH-1:0];
      end else begin
        cross_s    = sub_s[WIDTH];
        next_sum_s = sub_s[WIDTH-1:0];
      end
      if ((SATURATE != 0) && cross_s) begin
        next_sum_s = up ? MAX_VAL : MIN_VAL;
      end else begin
        next_sum_s = next_sum_s;
      end
    end else begin
      next_sum_s = sum_r;
    end
    // A crossing in the same cycle as a clear keeps the flag set.
    if (cross_s) begin
      next_stat_s = 1'b1;
    end else if (clr_ovf) begin
      next_stat_s = 1'b0;
    end else begin
      next_stat_s = stat_r;
    end
    next_tc_s = cross_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r  <= {WIDTH{1'b0}};
      stat_r <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      sum_r  <= next_sum_s;
      stat_r <= next_stat_s;
      tc_r   <= next_tc_s;
    end
  end

  assign sum  = sum_r;
  assign stat = stat_r;
  assign tc   = tc_r;

endmodule

// File: tb/tb_step_counter.sv
// Drives three step_counter configurations with shared stimulus and checks
// each against an integer-arithmetic reference model every cycle.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load, clr_ovf;
  logic [7:0] load_val;

  logic [1:0] sum0;
  logic [3:0] sum1;
  logic [7:0] sum2;
  logic       stat0, stat1, stat2, tc0, tc1, tc2;

  int total = 0;
  int bad   = 0;

  // Instance configurations: WIDTH, STEP, SATURATE
  int cfg_w   [3] = '{2, 4, 8};
  int cfg_s   [3] = '{1, 3, 1};
  int cfg_sat [3] = '{0, 1, 0};

  int m_sum  [3];
  int m_stat [3];
  int m_tc   [3];

  always #5 clk = ~clk;

  step_counter #(.WIDTH(2), .STEP(1), .SATURATE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val[1:0]), .clr_ovf(clr_ovf),
    .sum(sum0), .stat(stat0), .tc(tc0));

  step_counter #(.WIDTH(4), .STEP(3), .SATURATE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .clr_ovf(clr_ovf),
    .sum(sum1), .stat(stat1), .tc(tc1));

  step_counter #(.WIDTH(8), .STEP(1), .SATURATE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .sum(sum2), .stat(stat2), .tc(tc2));

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_sum(input int i);
    case (i)
      0: return int'(sum0);
      1: return int'(sum1);
      default: return int'(sum2);
    endcase
  endfunction

  function automatic int get_stat(input int i);
    case (i)
      0: return int'(stat0);
      1: return int'(stat1);
      default: return int'(stat2);
    endcase
  endfunction

  function automatic int get_tc(input int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  // Reference: the counter as a plain integer in 0..2^W-1.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int maxv = (1 << cfg_w[i]) - 1;
      if (!rst_n) begin
        m_sum[i] = 0; m_stat[i] = 0; m_tc[i] = 0;
      end else if (load) begin
        m_sum[i] = int'(load_val) & maxv;
        m_tc[i]  = 0;
        if (clr_ovf) m_stat[i] = 0;
      end else if (en) begin
        int n = up ? m_sum[i] + cfg_s[i] : m_sum[i] - cfg_s[i];
        int crossed = (n > maxv || n < 0) ? 1 : 0;
        if (crossed == 0) m_sum[i] = n;
        else if (cfg_sat[i] != 0) m_sum[i] = up ? maxv : 0;
        else if (n < 0) m_sum[i] = n + maxv + 1;
        else m_sum[i] = n - (maxv + 1);
        m_tc[i] = crossed;
        if (crossed != 0) m_stat[i] = 1;
        else if (clr_ovf) m_stat[i] = 0;
      end else begin
        m_tc[i] = 0;
        if (clr_ovf) m_stat[i] = 0;
      end
    end
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs read #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sum%0d", i),  get_sum(i),  m_sum[i]);
      check($sformatf("stat%0d", i), get_stat(i), m_stat[i]);
      check($sformatf("tc%0d", i),   get_tc(i),   m_tc[i]);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [7:0] lv,
                       input logic e, input logic u, input logic c);
    rst_n = r; load = l; load_val = lv; en = e; up = u; clr_ovf = c;
  endtask

  initial begin
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_stat[i] = 0; m_tc[i] = 0;
    end
    drive(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    cycle();
    check("reset_sum2", int'(sum2), 0);

    // 2-bit wrap counting 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      cycle();
      check("wrap_seq", int'(sum0), exp_seq[k]);
      check("wrap_tc", int'(tc0), (k == 3) ? 1 : 0);
      check("wrap_stat", int'(stat0), (k >= 3) ? 1 : 0);
    end

    // Clamp path on the saturating instance: 12 -> 15 -> 15 -> 15
    drive(1'b1, 1'b1, 8'd12, 1'b0, 1'b0, 1'b1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      cycle();
      check("sat_hold", int'(sum1), 15);
    end

    // Borrow from 0, then clear the flag while idle
    drive(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("borrow_sum", int'(sum2), 255);
    check("borrow_tc", int'(tc2), 1);
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("clr_stat", int'(stat2), 0);

    // Load beats a step from 255
    drive(1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
    cycle();
    check("load_prio", int'(sum2), 7);
    check("load_tc", int'(tc2), 0);

    // Crossing and clear in the same cycle: set wins
    drive(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
    cycle();
    check("set_wins_stat", int'(stat0), 1);
    check("set_wins_sum", int'(sum0), 0);

    // Reset mid-count discards the step, release resumes from 0
    drive(1'b1, 1'b1, 8'd99, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("count_100", int'(sum2), 100);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("mid_reset", int'(sum2), 0);
    drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("resume", int'(sum2), 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
